// File: rtl/switch_allocator_if.sv
// Switch allocator bus: routing requests and flit handshake in, crossbar control out.
//   req_valid/req_port        per-input routing request (slice i at [i*REQUEST_WIDTH +: REQUEST_WIDTH])
//   valid_in/ready_in/tail_in per-input flit handshake as seen by the crossbar
//   routeSelect               input index driving each output
//   outputBusy                output is allocated
//   PortReserved              input owns an output
// master drives requests and handshake; slave is the allocator.
interface switch_allocator_if #(
  parameter int unsigned INPUTS        = 4,
  parameter int unsigned OUTPUTS       = 4,
  parameter int unsigned REQUEST_WIDTH = 32
);
  logic [INPUTS-1:0]                req_valid;
  logic [INPUTS*REQUEST_WIDTH-1:0]  req_port;
  logic [INPUTS-1:0]                valid_in;
  logic [INPUTS-1:0]                ready_in;
  logic [INPUTS-1:0]                tail_in;
  logic [OUTPUTS*REQUEST_WIDTH-1:0] routeSelect;
  logic [OUTPUTS-1:0]               outputBusy;
  logic [INPUTS-1:0]                PortReserved;

  modport master (
    output req_valid, req_port, valid_in, ready_in, tail_in,
    input  routeSelect, outputBusy, PortReserved
  );

  modport slave (
    input  req_valid, req_port, valid_in, ready_in, tail_in,
    output routeSelect, outputBusy, PortReserved
  );
endinterface

// File: rtl/switch_allocator.sv
// Per-router switch allocator for a mux-based crossbar.
// Each output runs an Idle/Busy FSM with its own round-robin pointer; a grant holds the
// input->output path until the owning input transfers its tail flit.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  switch_allocator_if.slave (requests, handshake in; routeSelect/outputBusy/PortReserved out)
// All outputs are registered.
module switch_allocator #(
  parameter int unsigned INPUTS        = 4,
  parameter int unsigned OUTPUTS       = 4,
  parameter int unsigned REQUEST_WIDTH = 32
) (
  input logic               clk,
  input logic               rst,
  switch_allocator_if.slave bus
);

  localparam int unsigned PtrW = (INPUTS > 1) ? $clog2(INPUTS) : 1;

  typedef enum logic {StIdle, StBusy} out_state_e;

  out_state_e               state_q    [OUTPUTS];
  logic [REQUEST_WIDTH-1:0] route_q    [OUTPUTS];
  logic [PtrW-1:0]          ptr_q      [OUTPUTS];
  logic [INPUTS-1:0]        reserved_q;

  logic [REQUEST_WIDTH-1:0] port_arr   [INPUTS];
  logic [INPUTS-1:0]        elig       [OUTPUTS];
  logic [PtrW-1:0]          winner     [OUTPUTS];
  logic [OUTPUTS-1:0]       grant;
  logic [OUTPUTS-1:0]       rel;
  logic [INPUTS-1:0]        fire;

  // Arbitration and release detection.
  always_comb begin
    logic [PtrW-1:0] idx;
    idx  = '0;
    fire = bus.valid_in & bus.ready_in & bus.tail_in;
    for (int i = 0; i < int'(INPUTS); i++) begin
      port_arr[i] = bus.req_port[i*REQUEST_WIDTH +: REQUEST_WIDTH];
    end
    for (int o = 0; o < int'(OUTPUTS); o++) begin
      grant[o]  = 1'b0;
      rel[o]    = 1'b0;
      winner[o] = '0;
      // Out-of-range port values never match any output, so they are simply ignored.
      for (int i = 0; i < int'(INPUTS); i++) begin
        elig[o][i] = bus.req_valid[i] && !reserved_q[i] &&
                     (port_arr[i] == REQUEST_WIDTH'(o));
      end
      if (state_q[o] == StIdle) begin
        // First eligible input searching upward from the pointer, wrapping.
        for (int unsigned off = 0; off < INPUTS; off++) begin
          idx = PtrW'((32'(ptr_q[o]) + off) % INPUTS);
          if (elig[o][idx] && !grant[o]) begin
            grant[o]  = 1'b1;
            winner[o] = idx;
          end
        end
      end else begin
        for (int i = 0; i < int'(INPUTS); i++) begin
          if (route_q[o] == REQUEST_WIDTH'(i) && fire[i]) rel[o] = 1'b1;
        end
      end
    end
  end

  // Output FSMs, pointers, route registers and input reservations.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reserved_q <= '0;
      for (int o = 0; o < int'(OUTPUTS); o++) begin
        state_q[o] <= StIdle;
        route_q[o] <= '0;
        ptr_q[o]   <= '0;
      end
    end else begin
      for (int o = 0; o < int'(OUTPUTS); o++) begin
        if (grant[o]) begin
          state_q[o]             <= StBusy;
          route_q[o]             <= REQUEST_WIDTH'(winner[o]);
          ptr_q[o]               <= PtrW'((32'(winner[o]) + 1) % INPUTS);
          reserved_q[winner[o]]  <= 1'b1;
        end else if (rel[o]) begin
          // route_q keeps the old owner; harmless while the output is idle.
          state_q[o] <= StIdle;
          for (int i = 0; i < int'(INPUTS); i++) begin
            if (route_q[o] == REQUEST_WIDTH'(i)) reserved_q[i] <= 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    bus.routeSelect  = '0;
    bus.outputBusy   = '0;
    bus.PortReserved = reserved_q;
    for (int o = 0; o < int'(OUTPUTS); o++) begin
      bus.routeSelect[o*REQUEST_WIDTH +: REQUEST_WIDTH] = route_q[o];
      bus.outputBusy[o] = (state_q[o] == StBusy);
    end
  end

endmodule

// File: doc/switch_allocator.md
# switch_allocator

Per-router switch control block that drives the mux-based crossbar. It takes one routing request per input port, arbitrates each output port among its requesters with a per-output round-robin pointer, and holds the resulting input→output path until the packet's tail flit has transferred. Its outputs `routeSelect`, `outputBusy` and `PortReserved` feed the crossbar's select, output-routed and input-reserved inputs directly.

## Interface
- `INPUTS`, 4, number of input ports.
- `OUTPUTS`, 4, number of output ports.
- `REQUEST_WIDTH`, 32, width of one port index in requests and in `routeSelect`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `req_valid`  in  INPUTS  input i has a head flit waiting and requests output `req_port[i]`.
- `req_port`  in  INPUTS*REQUEST_WIDTH  requested output index per input, slice i at `[i*REQUEST_WIDTH +: REQUEST_WIDTH]`.
- `valid_in`  in  INPUTS  input-side valid, the same signal seen by the crossbar.
- `ready_in`  in  INPUTS  input-side ready, as returned by the crossbar.
- `tail_in`  in  INPUTS  the flit currently on input i is the last flit of its packet.
- `routeSelect`  out  OUTPUTS*REQUEST_WIDTH  input index driving each output.
- `outputBusy`  out  OUTPUTS  output o is allocated.
- `PortReserved`  out  INPUTS  input i owns an output.

## Operation
- Each output o has a 2-state FSM:
  - IDLE → BUSY when an arbitration grant occurs.
  - BUSY → IDLE on a release.
  - `outputBusy[o]` is 1 exactly in BUSY.
- Eligible requester for output o: input i with `req_valid[i]=1`, `req_port[i]==o`, and `PortReserved[i]=0`.
- Ignored requests: a `req_port` value ≥ OUTPUTS is never granted and never blocks other inputs.
- Arbitration for an output o in IDLE with at least one eligible requester:
  - Winner k is the first eligible input found searching upward from `ptr[o]`, wrapping modulo INPUTS.
  - Next edge: `routeSelect[o]=k`, `outputBusy[o]=1`, `PortReserved[k]=1`, `ptr[o]=(k+1) mod INPUTS`.
- Each input requests exactly one output, so two outputs never grant the same input in one cycle.
- An input holds at most one reservation. While BUSY, `routeSelect[o]` is frozen.
- Release of output o in BUSY with owner k:
  - Condition: `valid_in[k] & ready_in[k] & tail_in[k]` on a clock edge.
  - Next edge: `outputBusy[o]=0`, `PortReserved[k]=0`.
  - `routeSelect[o]` keeps its last value, which is harmless because `outputBusy=0`.
- Non-tail transfers and stalls (valid without ready) do not change state.
- Single-flit packets (head = tail) release on their first transfer.
- `ptr[o]` changes only on a grant to o.
- `req_valid[i]` and `req_port[i]` must stay stable until `PortReserved[i]` rises. The block does not latch requests.
- Reset, including mid-packet: all outputs and `ptr` clear to 0 immediately. In-flight packets are abandoned, and re-arbitration starts from scratch after deassertion.

## Timing
- Reset values: `routeSelect=0`, `outputBusy=0`, `PortReserved=0`, all `ptr=0`.
- Grant latency: request present at edge N (output IDLE) → grant outputs visible after edge N+1, i.e. 1 cycle. The crossbar can pass the head flit starting in that cycle.
- Release latency: tail transfer at edge N → `outputBusy`/`PortReserved` low after edge N.
- The next grant on the same output is visible after edge N+1, so there is exactly one IDLE cycle between packets on an output.
- A just-released input may be re-granted, to any output, with the same latency.
- Outputs are registered only, with no combinational path from inputs to outputs.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → all outputs 0 without waiting for a clock edge. After release with no requests, they stay 0.
- Single path: `req_valid[2]=1`, `req_port[2]=3` → one cycle later `outputBusy=4'b1000`, `routeSelect[3]=2`, `PortReserved=4'b0100`. A 3-flit packet with tail on the 3rd transfer → both flags clear the cycle after the tail fires.
- Round-robin: inputs 0, 1 and 3 all request output 1, with each packet one single-flit transfer.
  - Grants go in order 0, 1, 3, then 0 again.
  - Each grant is separated by a 1-cycle IDLE gap.
  - `ptr[1]` wraps from 0 to 1 to 2 (so 3 is found next) to 0.
- Parallel and contention: inputs 0→2 and 1→0 are granted in the same cycle. Input 3 also requesting 2 waits until the output 2 release, then gets `routeSelect[2]=3`.
- Stall and out-of-range: during a packet, `valid_in=1` with `ready_in=0` and `tail_in=1` → no release. An input with `req_port=7` and `OUTPUTS=4` is never granted, while other inputs still win.
- Reset mid-packet: `rst` pulse while output 2 is BUSY → all cleared. A held request is re-granted one cycle after `rst` deasserts, with `ptr` restarted at 0.
